// File: rtl/matmul_skew_feeder_pkg.sv
// Shared constants, FSM state type and skew indexing helper for the 4x4 systolic
// matrix multiplier front end.
package matmul_pkg;

  localparam int N          = 4;
  localparam int DATA_W     = 8;
  localparam int STREAM_LEN = 2*N - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } skew_t;

  // Lane 'lane' carries element index t-lane; outside 0..N-1 the lane is idle.
  function automatic skew_t skew_idx(input logic [2:0] t, input logic [1:0] lane);
    logic signed [3:0] d;
    skew_t s;
    d     = $signed({1'b0, t}) - $signed({2'b00, lane});
    s.vld = (d >= 4'sd0) && (d <= 4'sd3);
    s.idx = d[1:0];
    return s;
  endfunction

endpackage

// File: rtl/matmul_operand_store.sv
// Two 4x4 operand register files (A and B) with a single row-write port;
// every element is exposed flat, element [r][c] at bits (r*N+c)*DATA_W.
module matmul_operand_store
  import matmul_pkg::*;
#(
  parameter int DATA_W = matmul_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     sel,
  input  logic [1:0]               row,
  input  logic [N*DATA_W-1:0]      data,
  output logic [N*N*DATA_W-1:0]    a_flat,
  output logic [N*N*DATA_W-1:0]    b_flat
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_flat <= '0;
      b_flat <= '0;
    end else if (we) begin
      if (!sel) a_flat[int'(row)*N*DATA_W +: N*DATA_W] <= data;
      else      b_flat[int'(row)*N*DATA_W +: N*DATA_W] <= data;
    end
  end

endmodule

// File: rtl/matmul_skew_feeder.sv
// Operand feeder for the 4x4 systolic array: buffers A and B, clears the PEs,
// streams diagonally skewed rows/columns, waits for drain and pulses done.
module matmul_skew_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_W       = matmul_pkg::DATA_W,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_sel,
  input  logic [1:0]            load_row,
  input  logic [4*DATA_W-1:0]   load_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pe_clear,
  output logic [DATA_W-1:0]     a1,
  output logic [DATA_W-1:0]     a2,
  output logic [DATA_W-1:0]     a3,
  output logic [DATA_W-1:0]     a4,
  output logic [DATA_W-1:0]     b1,
  output logic [DATA_W-1:0]     b2,
  output logic [DATA_W-1:0]     b3,
  output logic [DATA_W-1:0]     b4
);

  localparam int             DCW   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [2:0]     TLAST = 3'(STREAM_LEN - 1);

  state_t                   state;
  logic [2:0]               tcnt;
  logic [DCW-1:0]           dcnt;
  logic                     we;
  logic [N*N*DATA_W-1:0]    a_flat;
  logic [N*N*DATA_W-1:0]    b_flat;
  logic [2:0]               tsel;
  skew_t                    sk;
  logic [DATA_W-1:0]        a_nxt [N];
  logic [DATA_W-1:0]        b_nxt [N];
  logic [DATA_W-1:0]        a_p0  [N];
  logic [DATA_W-1:0]        b_p0  [N];

  assign we = load_valid && load_ready;

  matmul_operand_store #(
    .DATA_W (DATA_W)
  ) u_store (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .sel    (load_sel),
    .row    (load_row),
    .data   (load_data),
    .a_flat (a_flat),
    .b_flat (b_flat)
  );

  function automatic logic [DATA_W-1:0] elem(input logic [N*N*DATA_W-1:0] m,
                                             input int r, input int c);
    return m[(r*N + c)*DATA_W +: DATA_W];
  endfunction

  // Stage p0 input: beat for the step about to be registered (t=0 out of CLEAR).
  always_comb begin
    tsel = (state == CLEAR) ? 3'd0 : tcnt + 3'd1;
    sk   = '0;
    for (int i = 0; i < N; i++) begin
      sk       = skew_idx(tsel, 2'(i));
      b_nxt[i] = sk.vld ? elem(a_flat, i, int'(sk.idx)) : '0;
      a_nxt[i] = sk.vld ? elem(b_flat, int'(sk.idx), i) : '0;
    end
  end

  // Stage p0: FSM and registered array-facing outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      dcnt       <= '0;
      pe_clear   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
      for (int i = 0; i < N; i++) begin
        a_p0[i] <= '0;
        b_p0[i] <= '0;
      end
    end else begin
      pe_clear <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            pe_clear   <= 1'b1;
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
        end
        CLEAR: begin
          state <= STREAM;
          tcnt  <= '0;
          a_p0  <= a_nxt;
          b_p0  <= b_nxt;
        end
        STREAM: begin
          if (tcnt == TLAST) begin
            for (int i = 0; i < N; i++) begin
              a_p0[i] <= '0;
              b_p0[i] <= '0;
            end
            dcnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state      <= IDLE;
              done       <= 1'b1;
              busy       <= 1'b0;
              load_ready <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            tcnt <= tcnt + 3'd1;
            a_p0 <= a_nxt;
            b_p0 <= b_nxt;
          end
        end
        DRAIN: begin
          if (dcnt == DLAST) begin
            state      <= IDLE;
            done       <= 1'b1;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a1 = a_p0[0];
  assign a2 = a_p0[1];
  assign a3 = a_p0[2];
  assign a4 = a_p0[3];
  assign b1 = b_p0[0];
  assign b2 = b_p0[1];
  assign b3 = b_p0[2];
  assign b4 = b_p0[3];

endmodule

// File: tb/tb_matmul_skew_feeder.sv
// Scoreboard bench for matmul_skew_feeder driving a behavioural 4x4 systolic
// array, so both the raw streams and the resulting product are checked.
module tb_matmul_skew_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_sel = 1'b0;
  logic [1:0]  load_row = 2'd0;
  logic [31:0] load_data = 32'd0;
  logic        start = 1'b0;
  logic        load_ready, busy, done, pe_clear;
  logic [7:0]  a1, a2, a3, a4, b1, b2, b3, b4;

  always #5 clk = ~clk;

  matmul_skew_feeder #(.DATA_W(8), .DRAIN_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sel   (load_sel),
    .load_row   (load_row),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pe_clear   (pe_clear),
    .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4),
    .b1 (b1), .b2 (b2), .b3 (b3), .b4 (b4)
  );

  typedef struct packed {
    logic        pc;
    logic        bz;
    logic        dn;
    logic [31:0] av;
    logic [31:0] bv;
  } rec_t;

  rec_t       sb[$];
  int         cq[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  // Behavioural systolic array: a flows down the columns, b flows right along rows.
  logic [7:0] as_in [4];
  logic [7:0] bs_in [4];
  bit   [7:0] ar [4][4];
  bit   [7:0] br [4][4];
  int         acc [4][4];
  bit   [7:0] pa, pb;

  always_comb begin
    as_in[0] = a1; as_in[1] = a2; as_in[2] = a3; as_in[3] = a4;
    bs_in[0] = b1; bs_in[1] = b2; bs_in[2] = b3; bs_in[3] = b4;
  end

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pa = (r == 0) ? as_in[c] : ar[(r == 0) ? 0 : r-1][c];
        pb = (c == 0) ? bs_in[r] : br[r][(c == 0) ? 0 : c-1];
        ar[r][c] <= pa;
        br[r][c] <= pb;
        if (pe_clear) acc[r][c] <= 0;
        else          acc[r][c] <= acc[r][c] + int'(pa) * int'(pb);
      end
    end
  end

  // Monitor: every active output cycle is matched against the next expected record.
  rec_t mon_act, mon_exp;
  int   mon_e;
  always @(negedge clk) begin
    if (busy || done || pe_clear) begin
      mon_act = {pe_clear, busy, done, {a4, a3, a2, a1}, {b4, b3, b2, b1}};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stream_unexpected act=%h exp=none", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL stream_cycle act=%h exp=%h", mon_act, mon_exp);
        end
      end
      if (done) begin
        for (int k = 0; k < 16; k++) begin
          total++;
          if (cq.size() == 0) begin
            bad++;
            $display("FAIL product_unexpected c%0d act=%0d exp=none", k+1, acc[k/4][k%4]);
          end else begin
            mon_e = cq.pop_front();
            if (acc[k/4][k%4] != mon_e) begin
              bad++;
              $display("FAIL product c%0d act=%0d exp=%0d", k+1, acc[k/4][k%4], mon_e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic load(input bit sel, input int row, input logic [31:0] d);
    load_valid = 1'b1;
    load_sel   = sel;
    load_row   = row[1:0];
    load_data  = d;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (sel) mb[row][c] = d[8*c +: 8];
      else     ma[row][c] = d[8*c +: 8];
    end
  endtask

  task automatic push_run();
    rec_t r;
    int   s;
    r = '0; r.pc = 1'b1; r.bz = 1'b1;
    sb.push_back(r);
    for (int t = 0; t < 7; t++) begin
      r = '0; r.bz = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (t - i >= 0 && t - i <= 3) begin
          r.bv[8*i +: 8] = ma[i][t-i];
          r.av[8*i +: 8] = mb[t-i][i];
        end
      end
      sb.push_back(r);
    end
    for (int d = 0; d < 4; d++) begin
      r = '0; r.bz = 1'b1;
      sb.push_back(r);
    end
    r = '0; r.dn = 1'b1;
    sb.push_back(r);
    for (int rr = 0; rr < 4; rr++) begin
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(ma[rr][k]) * int'(mb[k][c]);
        cq.push_back(s);
      end
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout act=no_done exp=done_within_60");
    end
  endtask

  task automatic run_plain();
    int cyc;
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    check("done_latency", cyc, 12);
  endtask

  initial begin
    int cyc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'd0;
        mb[r][c] = 8'd0;
      end

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pe_clear", pe_clear, 0);
    check("reset_a", {a4, a3, a2, a1}, 0);
    check("reset_b", {b4, b3, b2, b1}, 0);
    rst_n = 1'b1;
    tick();
    check("reset_load_ready", load_ready, 1);

    // Identity times 1..16 with hand-computed beats.
    load(0, 0, 32'h00000001); load(0, 1, 32'h00000100);
    load(0, 2, 32'h00010000); load(0, 3, 32'h01000000);
    load(1, 0, 32'h04030201); load(1, 1, 32'h08070605);
    load(1, 2, 32'h0C0B0A09); load(1, 3, 32'h100F0E0D);
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e0_pe_clear", pe_clear, 1);
    check("e0_load_ready", load_ready, 0);
    check("e0_streams", {a4, a3, a2, a1, b4, b3, b2, b1}, 0);
    tick();
    check("t0_a1", a1, 1);
    check("t0_b1", b1, 1);
    check("t0_a2", a2, 0);
    tick();
    check("t1_a1", a1, 5);
    check("t1_a2", a2, 2);
    check("t1_b1", b1, 0);
    check("t1_b2", b2, 0);
    tick(); tick();
    check("t3_a4", a4, 4);
    tick(); tick(); tick();
    check("t6_a4", a4, 16);
    check("t6_b4", b4, 1);
    wait_done(cyc);
    check("done_after_e12", cyc, 5);
    check("ident_c1", acc[0][0], 1);
    check("ident_c16", acc[3][3], 16);
    tick();
    check("idle_load_ready", load_ready, 1);

    // All-255 operands, then again without reloading.
    for (int r = 0; r < 4; r++) begin
      load(0, r, 32'hFFFFFFFF);
      load(1, r, 32'hFFFFFFFF);
    end
    run_plain();
    check("max_c7", acc[1][2], 260100);
    run_plain();
    check("max_repeat_c16", acc[3][3], 260100);

    // General operands; a write attempt during STREAM must be ignored.
    load(0, 0, 32'h04030201); load(0, 1, 32'h02000100);
    load(0, 2, 32'h01000005); load(0, 3, 32'h02020202);
    load(1, 0, 32'h00020001); load(1, 1, 32'h01000300);
    load(1, 2, 32'h00010004); load(1, 3, 32'h05000100);
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    load_valid = 1'b1; load_sel = 1'b0; load_row = 2'd0; load_data = 32'd0;
    check("stream_load_ready", load_ready, 0);
    tick();
    load_valid = 1'b0;
    wait_done(cyc);
    run_plain();
    check("general_c1", acc[0][0], 13);

    // Load and start in the same IDLE cycle: the new B row 2 is streamed.
    load_valid = 1'b1; load_sel = 1'b1; load_row = 2'd2; load_data = 32'h09090909;
    for (int c = 0; c < 4; c++) mb[2][c] = 8'd9;
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    wait_done(cyc);
    check("loadstart_latency", cyc, 12);
    check("loadstart_c1", acc[0][0], 1 + 27);

    // start held high: back-to-back runs 13 cycles apart.
    push_run(); push_run(); push_run();
    start = 1'b1;
    tick();
    wait_done(cyc);
    check("b2b_first", cyc, 12);
    tick();
    wait_done(cyc);
    check("b2b_period2", cyc + 1, 13);
    tick();
    wait_done(cyc);
    start = 1'b0;
    check("b2b_period3", cyc + 1, 13);
    tick();
    tick();
    check("b2b_stopped_busy", busy, 0);

    // Reset while streams are active.
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_load_ready", load_ready, 1);
    check("midrst_streams", {a4, a3, a2, a1, b4, b3, b2, b1}, 0);
    rst_n = 1'b1;
    sb.delete();
    cq.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'd0;
        mb[r][c] = 8'd0;
      end
    repeat (20) tick();
    run_plain();
    check("cleared_c1", acc[0][0], 0);

    tick();
    check("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
